// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU control codes, ALU-op selector and the 4-bit controller state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_J        = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // IDLE drives alucontrol to 000 in states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IDLE  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's aluop plus op/funct to the 3-bit
// alucontrol, and flags whether op/funct names a supported R/SPECIAL2 op.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o,
    output logic       funct_valid_o
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl    = ALU_ADD;
        funct_valid_o = 1'b0;
        if (op_i == OP_SPECIAL2) begin
            if (funct_i == F_MUL) begin
                funct_ctrl    = ALU_MUL;
                funct_valid_o = 1'b1;
            end
        end else begin
            funct_valid_o = 1'b1;
            case (funct_i)
                F_ADD:   funct_ctrl = ALU_ADD;
                F_SUB:   funct_ctrl = ALU_SUB;
                F_AND:   funct_ctrl = ALU_AND;
                F_OR:    funct_ctrl = ALU_OR;
                F_SLT:   funct_ctrl = ALU_SLT;
                default: funct_valid_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (aluop_i)
            ALUOP_ADD:   alucontrol_o = ALU_ADD;
            ALUOP_SUB:   alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: alucontrol_o = funct_ctrl;
            default:     alucontrol_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences each
// instruction and drives every datapath select/enable from the current state.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pcwrite, branch, bne, funct_valid;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        aluop    = ALUOP_IDLE;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                aluop   = ALUOP_ADD;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BEQEX;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JEX;
                    OP_RTYPE, OP_SPECIAL2: begin
                        if (funct_valid) state_d = S_RTYPEEX;
                        else             illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                bne     = (op == OP_BNE);
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every output, including alucontrol via the IDLE aluop.
        if (reset) begin
            aluop    = ALUOP_IDLE;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            illegal  = 1'b0;
        end
        pcen = pcwrite | (branch & (zero ^ bne));
    end

    alu_decoder u_alu_decoder (
        .aluop_i       (aluop),
        .op_i          (op),
        .funct_i       (funct),
        .alucontrol_o  (alucontrol),
        .funct_valid_o (funct_valid)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } ctl_t;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BR = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int total = 0;
    int bad = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // ALU code for a register-type instruction, or -1 if unsupported.
    function automatic int r_code(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b011100) return (f == 6'b000010) ? 3 : -1;
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100, 6'b000101: return C_BR;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            6'b000000, 6'b011100: return (r_code(o, f) >= 0) ? C_R : C_ILL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int unsigned inst_len(input int cls);
        case (cls)
            C_LW:             return 5;
            C_SW, C_R, C_ADDI: return 4;
            C_BR, C_J:        return 3;
            default:          return 2;
        endcase
    endfunction

    // Expected control word for cycle k (0 = fetch) of one instruction.
    function automatic ctl_t expect_cycle(input logic [5:0] o, input logic [5:0] f,
                                          input int unsigned k, input logic z);
        ctl_t e;
        int cls;
        e = '0;
        cls = classify(o, f);
        if (k == 0) begin
            e.alusrcb = 2'b01; e.aluc = 3'b010; e.irwrite = 1'b1; e.pcen = 1'b1;
        end else if (k == 1) begin
            e.alusrcb = 2'b11; e.aluc = 3'b010; e.illegal = (cls == C_ILL);
        end else begin
            case (cls)
                C_LW, C_SW: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
                    end else if (k == 3) begin
                        e.iord = 1'b1; e.memwrite = (cls == C_SW);
                    end else begin
                        e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    end
                end
                C_R: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1; e.aluc = 3'(r_code(o, f));
                    end else begin
                        e.regdst = 1'b1; e.regwrite = 1'b1;
                    end
                end
                C_BR: begin
                    e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
                    e.pcen = z ^ (o == 6'b000101);
                end
                C_ADDI: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
                    end else begin
                        e.regwrite = 1'b1;
                    end
                end
                C_J: begin
                    e.pcsrc = 2'b10; e.pcen = 1'b1;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        ctl_t act;
        act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, alucontrol, illegal};
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // zmode: 0/1 force zero, 2 random each cycle. ncyc=0 runs the whole instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int unsigned ncyc);
        int unsigned len;
        len = inst_len(classify(o, f));
        if (ncyc != 0 && ncyc < len) len = ncyc;
        for (int unsigned k = 0; k < len; k++) begin
            @(negedge clk);
            reset = 1'b0;
            // The instruction register only holds the new word after fetch.
            op    = (k == 0) ? 6'($urandom) : o;
            funct = (k == 0) ? 6'($urandom) : f;
            zero  = (zmode == 2) ? 1'($urandom) : zmode[0];
            #1;
            check($sformatf("op%b_f%b_c%0d", o, f, k + 1), expect_cycle(o, f, k, zero));
        end
    endtask

    task automatic reset_cycles(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            op    = 6'($urandom);
            funct = 6'($urandom);
            zero  = 1'($urandom);
            #1;
            check($sformatf("%s_%0d", tag, i), '0);
        end
    endtask

    logic [5:0] legal_ops [8];
    logic [5:0] r_functs  [5];

    initial begin
        legal_ops = '{6'b000000, 6'b011100, 6'b100011, 6'b101011,
                      6'b000100, 6'b000101, 6'b001000, 6'b000010};
        r_functs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset_cycles("reset", 2);

        run_instr(6'b100011, 6'b000000, 2, 0);  // lw
        run_instr(6'b101011, 6'b111111, 2, 0);  // sw
        run_instr(6'b000000, 6'b100000, 2, 0);  // add
        run_instr(6'b000000, 6'b100010, 2, 0);  // sub
        run_instr(6'b000000, 6'b100100, 2, 0);  // and
        run_instr(6'b000000, 6'b100101, 2, 0);  // or
        run_instr(6'b000000, 6'b101010, 2, 0);  // slt
        run_instr(6'b011100, 6'b000010, 2, 0);  // mul
        run_instr(6'b000100, 6'b000000, 1, 0);  // beq taken
        run_instr(6'b000100, 6'b000000, 0, 0);  // beq not taken
        run_instr(6'b000101, 6'b000000, 1, 0);  // bne not taken
        run_instr(6'b000101, 6'b000000, 0, 0);  // bne taken
        run_instr(6'b001000, 6'b010101, 2, 0);  // addi
        run_instr(6'b000010, 6'b000000, 2, 0);  // j
        run_instr(6'b111111, 6'b100000, 2, 0);  // illegal op
        run_instr(6'b000000, 6'b000111, 2, 0);  // illegal R funct
        run_instr(6'b011100, 6'b100000, 2, 0);  // illegal SPECIAL2 funct

        // Reset held two cycles while in MEMRD, then a clean fetch.
        run_instr(6'b100011, 6'b000000, 2, 3);
        reset_cycles("rst_memrd", 2);
        // Reset landing on the MEMWR cycle must suppress memwrite.
        run_instr(6'b101011, 6'b000000, 2, 3);
        reset_cycles("rst_memwr", 1);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 7)];
            else                          o = 6'($urandom);
            if (o == 6'b011100 && $urandom_range(0, 3) != 0) f = 6'b000010;
            else if ($urandom_range(0, 9) < 8)                f = r_functs[$urandom_range(0, 4)];
            else                                               f = 6'($urandom);
            run_instr(o, f, 2, 0);
            if ($urandom_range(0, 49) == 0) reset_cycles("rst_rand", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
